// File: rtl/spsram_burst_ctrl.sv
// spsram_burst_ctrl
// Burst controller in front of a single-port synchronous SRAM with one cycle
// of read latency. A request describes a burst (start address, beats-1,
// direction). Writes stream straight through to the SRAM as write data
// arrives. Reads are issued at up to one per cycle and land in a 2-entry
// response FIFO, so the read consumer may stall without losing data.
//
// state  | meaning
// IDLE   | waiting for a request; request port ready
// WRITE  | one SRAM write per cycle that write data is valid
// READ   | issuing SRAM reads while the response FIFO has room
// DRAIN  | all reads issued; waiting for the last beat to be consumed
//
// Ports
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_req_valid/o_req_ready              request handshake
//   i_req_wr, i_req_addr, i_req_len      direction (1=write), start addr, beats-1
//   i_wdata_valid/o_wdata_ready, i_wdata write data stream
//   o_rdata_valid/i_rdata_ready          read data stream
//   o_rdata, o_rdata_last                read beat and final-beat marker
//   o_sram_addr/data/cen/wen/oen         SRAM command side
//   i_sram_data                          SRAM read data (1 cycle after issue)
//   o_busy                               high whenever not IDLE
module spsram_burst_ctrl #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_wr,
    input  logic [BW_ADDR-1:0] i_req_addr,
    input  logic [BW_ADDR-1:0] i_req_len,
    input  logic               i_wdata_valid,
    output logic               o_wdata_ready,
    input  logic [BW_DATA-1:0] i_wdata,
    output logic               o_rdata_valid,
    input  logic               i_rdata_ready,
    output logic [BW_DATA-1:0] o_rdata,
    output logic               o_rdata_last,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_data,
    output logic               o_sram_cen,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    input  logic [BW_DATA-1:0] i_sram_data,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [BW_ADDR-1:0] r_addr;
    logic [BW_ADDR-1:0] r_left;          // beats remaining after the current one
    logic               r_rd_pend;       // read issued last cycle, data arrives this edge
    logic               r_rd_pend_last;

    logic [BW_DATA-1:0] r_fifo_data [2];
    logic               r_fifo_last [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    logic               w_accept;
    logic               w_wbeat;
    logic               w_issue;
    logic               w_cen;
    logic               w_wen;
    logic               w_push;
    logic               w_pop;
    logic               w_last_beat;
    logic [2:0]         w_occ_after;
    logic               w_credit;

    assign w_push      = r_rd_pend;
    assign w_pop       = o_rdata_valid & i_rdata_ready;
    assign w_last_beat = (r_left == '0);

    // A read issued now is written into the FIFO on the edge after next.
    // Counting this cycle's pop and the read already in flight keeps the FIFO
    // from overflowing while still allowing one read per cycle when the
    // consumer never stalls.
    assign w_occ_after = {1'b0, r_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_credit    = (w_occ_after < 3'd2);

    always_comb begin
        w_state_nxt   = r_state;
        o_req_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_sram_oen    = 1'b0;
        w_cen         = 1'b0;
        w_wen         = 1'b0;
        w_accept      = 1'b0;
        w_wbeat       = 1'b0;
        w_issue       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = i_req_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                o_wdata_ready = 1'b1;
                if (i_wdata_valid) begin
                    w_cen   = 1'b1;
                    w_wen   = 1'b1;
                    w_wbeat = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                o_sram_oen = 1'b1;
                if (w_credit) begin
                    w_cen   = 1'b1;
                    w_issue = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                o_sram_oen = 1'b1;
                if (w_pop && o_rdata_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset blocks any SRAM access in the same cycle it is asserted.
    assign o_sram_cen    = w_cen & ~i_rst;
    assign o_sram_wen    = w_wen & ~i_rst;
    assign o_sram_addr   = r_addr;
    assign o_sram_data   = i_wdata;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_rdata_valid = (r_count != 2'd0);
    assign o_rdata       = r_fifo_data[r_rptr];
    assign o_rdata_last  = o_rdata_valid & r_fifo_last[r_rptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_left         <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_rd_pend      <= w_issue;
            r_rd_pend_last <= w_issue & w_last_beat;
            if (w_accept) begin
                r_addr <= i_req_addr;
                r_left <= i_req_len;
            end else if (w_wbeat || w_issue) begin
                r_addr <= r_addr + BW_ADDR'(1);
                r_left <= r_left - BW_ADDR'(1);
            end
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // FIFO storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_fifo_data[r_wptr] <= i_sram_data;
            r_fifo_last[r_wptr] <= r_rd_pend_last;
        end
    end

endmodule

// File: tb/tb_spsram_burst_ctrl.sv
module tb_spsram_burst_ctrl;

    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_wr = 1'b0;
    logic [BW_ADDR-1:0] req_addr = '0;
    logic [BW_ADDR-1:0] req_len = '0;
    logic               wdata_valid = 1'b0;
    logic               wdata_ready;
    logic [BW_DATA-1:0] wdata = '0;
    logic               rdata_valid;
    logic               rdata_ready = 1'b1;
    logic [BW_DATA-1:0] rdata;
    logic               rdata_last;
    logic [BW_ADDR-1:0] sram_addr;
    logic [BW_DATA-1:0] sram_wdata;
    logic               sram_cen;
    logic               sram_wen;
    logic               sram_oen;
    logic [BW_DATA-1:0] sram_q = '0;
    logic               busy;

    spsram_burst_ctrl #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .i_wdata_valid(wdata_valid),
        .o_wdata_ready(wdata_ready),
        .i_wdata      (wdata),
        .o_rdata_valid(rdata_valid),
        .i_rdata_ready(rdata_ready),
        .o_rdata      (rdata),
        .o_rdata_last (rdata_last),
        .o_sram_addr  (sram_addr),
        .o_sram_data  (sram_wdata),
        .o_sram_cen   (sram_cen),
        .o_sram_wen   (sram_wen),
        .o_sram_oen   (sram_oen),
        .i_sram_data  (sram_q),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous, one cycle read latency
    logic [BW_DATA-1:0] mem [16];
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_q <= mem[sram_addr];
        end
    end

    typedef struct packed {
        logic [BW_DATA-1:0] d;
        logic               l;
    } exp_t;

    exp_t               exp_q[$];
    logic [BW_DATA-1:0] exp_mem [16];
    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int n_issued = 0;
    int max_out  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a read beat
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_cen && !sram_wen) n_issued++;
            if (rdata_valid && rdata_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rdata", rdata, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rdata_last", {31'b0, rdata_last}, {31'b0, e.l});
                end
            end
            if (n_issued - n_pops > max_out) max_out = n_issued - n_pops;
        end
    end

    task automatic send_req(input logic wr, input logic [3:0] a, input logic [3:0] l);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_len   = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] a, input logic [3:0] l,
                            input logic [31:0] base, input bit gaps);
        int beat = 0;
        int cyc = 0;
        logic [3:0] cur = a;
        logic wv;
        send_req(1'b1, a, l);
        while (beat <= int'(l) && cyc < 100) begin
            wv = gaps ? (cyc % 3 == 0) : 1'b1;
            wdata_valid = wv;
            wdata = base + beat;
            #1;
            chk("wr_cen", {31'b0, sram_cen}, {31'b0, wv});
            chk("wr_addr", {28'b0, sram_addr}, {28'b0, cur});
            @(posedge clk); #1;
            if (wv) begin
                exp_mem[cur] = base + beat;
                beat++;
                cur = cur + 4'd1;
            end
            cyc++;
        end
        wdata_valid = 1'b0;
        chk("wr_idle_after_last", {31'b0, busy}, 32'd0);
        for (int i = 0; i <= int'(l); i++) begin
            logic [3:0] ai;
            ai = a + 4'(i);
            chk("mem_contents", mem[ai], base + i);
        end
    endtask

    // mode 0: ready held high with latency/throughput checks; mode 1: 1,0,0,1 pattern
    task automatic rd_burst(input logic [3:0] a, input logic [3:0] l, input int mode);
        int cyc = 0;
        for (int i = 0; i <= int'(l); i++) begin
            exp_t e;
            logic [3:0] ai;
            ai = a + 4'(i);
            e.d = exp_mem[ai];
            e.l = (i == int'(l));
            exp_q.push_back(e);
        end
        n_issued = 0;
        n_pops   = 0;
        max_out  = 0;
        rdata_ready = 1'b1;
        send_req(1'b0, a, l);
        if (mode == 0) begin
            for (int n = 1; n <= int'(l) + 3; n++) begin
                @(posedge clk); #1;
                if (n == 1)
                    chk("rd_latency_not_early", {31'b0, rdata_valid}, 32'd0);
                else if (n <= int'(l) + 2)
                    chk("rd_streaming_valid", {31'b0, rdata_valid}, 32'd1);
                else begin
                    chk("rd_done_valid", {31'b0, rdata_valid}, 32'd0);
                    chk("rd_done_idle", {31'b0, busy}, 32'd0);
                end
            end
        end else begin
            while (exp_q.size() > 0 && cyc < 200) begin
                rdata_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                @(posedge clk); #1;
                cyc++;
            end
            rdata_ready = 1'b1;
            @(posedge clk); #1;
            chk("rd_max_outstanding_le2", {31'b0, (max_out <= 2)}, 32'd1);
            chk("rd_beats_delivered", n_pops, int'(l) + 1);
            chk("rd_idle", {31'b0, busy}, 32'd0);
        end
        chk("rd_scoreboard_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int p0;
        int guard;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("cen_low_in_reset", {31'b0, sram_cen}, 32'd0);
        rst = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        chk("rst_rdata_last", {31'b0, rdata_last}, 32'd0);
        chk("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
        chk("rst_sram_cen", {31'b0, sram_cen}, 32'd0);
        chk("rst_sram_wen", {31'b0, sram_wen}, 32'd0);
        chk("rst_sram_oen", {31'b0, sram_oen}, 32'd0);

        // basic write then read back
        wr_burst(4'd2, 4'd3, 32'h0000_00A0, 1'b0);
        rd_burst(4'd2, 4'd3, 0);

        // address wrap 14,15,0,1
        wr_burst(4'd14, 4'd3, 32'h0000_00C0, 1'b0);
        chk("wrap_mem0", mem[0], 32'h0000_00C2);
        chk("wrap_mem1", mem[1], 32'h0000_00C3);
        rd_burst(4'd14, 4'd3, 0);

        // full-depth write, then stalled read
        wr_burst(4'd0, 4'd15, 32'h0000_0100, 1'b0);
        rd_burst(4'd4, 4'd7, 1);

        // write with data-valid gaps
        wr_burst(4'd8, 4'd2, 32'h0000_00D0, 1'b1);

        // reset during the third beat of a read
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.d = exp_mem[i];
            e.l = (i == 7);
            exp_q.push_back(e);
        end
        rdata_ready = 1'b1;
        p0 = n_pops;
        send_req(1'b0, 4'd0, 4'd7);
        guard = 0;
        while (n_pops - p0 < 2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("abort_two_beats_seen", {31'b0, (n_pops - p0 >= 2)}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cen_low_in_reset", {31'b0, sram_cen}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("abort_inflight_discarded", {31'b0, rdata_valid}, 32'd0);
        rd_burst(4'd5, 4'd2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spsram_burst_ctrl.md
SPSRAM_BURST_CTRL -- requirements
Module: spsram_burst_ctrl

Interface
REQ-001 Parameter BW_DATA, default 32, data width; SHALL equal attached spsram BW_DATA.
REQ-002 Parameter BW_ADDR, default 4, address width; memory depth 2**BW_ADDR.
REQ-003 One clock; reset is synchronous and active-high. Ports: i_clk in 1 clock; i_rst in 1 sync active-high reset.
REQ-004 Request port: i_req_valid in 1; o_req_ready out 1; i_req_wr in 1 (1=write, 0=read); i_req_addr in BW_ADDR start address; i_req_len in BW_ADDR beats-1.
REQ-005 Write data port: i_wdata_valid in 1; o_wdata_ready out 1; i_wdata in BW_DATA.
REQ-006 Read data port: o_rdata_valid out 1; i_rdata_ready in 1; o_rdata out BW_DATA; o_rdata_last out 1 (final beat of burst).
REQ-007 SRAM side: o_sram_addr out BW_ADDR; o_sram_data out BW_DATA; o_sram_cen out 1; o_sram_wen out 1; o_sram_oen out 1; i_sram_data in BW_DATA; o_busy out 1.

Function
REQ-008 FSM states SHALL be IDLE, WRITE, READ, DRAIN.
REQ-009 IDLE: o_req_ready=1; request accepted on i_req_valid&o_req_ready; latch addr, len, wr; go WRITE if wr=1 else READ.
REQ-010 o_req_ready SHALL be 0 in every non-IDLE state; o_busy = (state!=IDLE).
REQ-011 WRITE: o_wdata_ready=1; on each cycle with i_wdata_valid=1, drive o_sram_cen=1, o_sram_wen=1, o_sram_addr=current addr, o_sram_data=i_wdata (combinational, same cycle); beat counter +1, addr +1.
REQ-012 WRITE with i_wdata_valid=0: o_sram_cen=0, no address advance.
REQ-013 Last write beat (count==len) accepted -> IDLE next cycle; o_rdata_valid never asserted for writes.
REQ-014 READ: issue one read per cycle (o_sram_cen=1, o_sram_wen=0, o_sram_oen=1) only when response-buffer occupancy + reads in flight < 2.
REQ-015 SRAM read latency is 1 cycle: i_sram_data sampled on the edge after the issue edge and written into a 2-entry response FIFO together with its last flag.
REQ-016 After the final read is issued -> DRAIN; DRAIN holds o_sram_oen=1, o_sram_cen=0, until the last beat is popped (o_rdata_valid&i_rdata_ready&o_rdata_last) -> IDLE.
REQ-017 o_sram_oen SHALL be 1 in READ and DRAIN, 0 in IDLE and WRITE.
REQ-018 o_rdata/o_rdata_last SHALL come from FIFO head; o_rdata_valid = FIFO non-empty; pop on valid&ready; push and pop in same cycle SHALL both occur, occupancy unchanged.
REQ-019 Burst length = i_req_len+1, range 1..2**BW_ADDR beats.
REQ-020 Address increments modulo 2**BW_ADDR; all-ones wraps to 0 mid-burst.
REQ-021 With i_rdata_ready held 1, read throughput SHALL be 1 beat/cycle; first o_rdata_valid 2 cycles after request acceptance.
REQ-022 With i_rdata_ready=0, at most 2 reads outstanding; no beat lost or duplicated.
REQ-023 In IDLE: o_sram_cen=0, o_sram_wen=0, o_wdata_ready=0.

Reset
REQ-024 i_rst=1 SHALL force IDLE, clear FIFO, counters, in-flight tracking at next edge.
REQ-025 Reset values: o_req_ready=1 in first cycle after reset, o_busy=0, o_rdata_valid=0, o_rdata_last=0, o_wdata_ready=0, o_sram_cen=0, o_sram_wen=0, o_sram_oen=0.
REQ-026 Reset mid-burst SHALL abort the burst; in-flight SRAM read data SHALL be discarded, not pushed.
REQ-027 While i_rst=1, o_sram_cen SHALL be 0 (no SRAM writes during reset).

Verification
REQ-028 Write addr=2, len=3, data A0..A3 continuous -> SRAM mem[2..5]=A0..A3, IDLE 1 cycle after last beat.
REQ-029 Read addr=2, len=3, i_rdata_ready=1 -> A0..A3 on consecutive cycles, last on A3, first valid 2 cycles after accept.
REQ-030 Write addr=14, len=3 then read same -> mem[14],mem[15],mem[0],mem[1] hit in order (wrap).
REQ-031 Read len=7 with i_rdata_ready toggled 1,0,0,1 pattern -> all 8 beats in order, never >2 outstanding, no SRAM read while full.
REQ-032 Write with i_wdata_valid gaps -> o_sram_cen low in gap cycles, address unchanged across gaps.
REQ-033 i_rst pulsed during 3rd beat of a len=7 read -> o_rdata_valid=0 next cycle, o_req_ready=1, subsequent read returns correct data.
